cs_udp_cmd_link_endpoint: RTL and testbench
===========================================

Name: cs_udp_cmd_link_endpoint

Overview:
CS-FPGA end of the ETH<->CS byte link. Receives UDP command bytes (vld/last/parity/byte) from the ETH FPGA, checks even parity, buffers them and releases complete command frames to local CS command logic. In the reverse direction it accepts reply Ethernet frames from local logic, buffers them, and streams them to the ETH FPGA with even parity, honouring the ETH FPGA's read/back-pressure. Single clock domain (i_sys_clk).

Parameters:
CMD_FIFO_DEPTH, 512, command buffer depth in bytes; power of two, >= 2*CMD_AFULL_MARGIN.
CMD_AFULL_MARGIN, 16, free entries left when o_udp_cmd_byte_rd drops; covers ETH-side pipeline latency.
RPL_FIFO_DEPTH, 2048, reply buffer depth in bytes; power of two, >= one max Ethernet frame.

Ports:
i_sys_clk  in  1  system clock
i_sys_rst_n  in  1  asynchronous active-low reset
i_udp_cmd_byte_vld  in  1  command byte valid from ETH FPGA (not gated by our rd)
i_udp_cmd_last_byte  in  1  last byte of command frame
i_udp_cmd_byte_parity  in  1  even parity of i_udp_cmd_byte
i_udp_cmd_byte  in  8  command data byte
o_udp_cmd_byte_rd  out  1  read/ready to ETH FPGA, registered
o_cmd_frame_avail  out  1  >=1 complete command frame buffered
o_cmd_byte_vld  out  1  command byte valid to local logic
o_cmd_last_byte  out  1  last byte of command frame
o_cmd_byte  out  8  command byte
i_cmd_byte_rd  in  1  local logic pops current byte
i_rpl_byte_vld  in  1  reply byte valid from local logic
i_rpl_last_byte  in  1  last byte of reply frame
i_rpl_byte  in  8  reply byte
o_rpl_byte_rdy  out  1  reply buffer can accept a byte
i_eth_frame_byte_rd  in  1  read/ready from ETH FPGA
o_eth_frame_byte_vld  out  1  reply byte valid to ETH FPGA
o_eth_frame_last_byte  out  1  last byte of reply frame
o_eth_frame_byte_parity  out  1  even parity (XOR of byte)
o_eth_frame_byte  out  8  reply byte
o_parity_errors  out  32  command-byte parity error count
o_cmd_overflows  out  16  command bytes dropped due to full buffer
o_frames_dropped  out  16  command frames discarded (feature only)

Behaviour:
- Reset (async, i_sys_rst_n=0): all outputs 0, counters 0, FIFOs empty. o_udp_cmd_byte_rd rises on first clock edge after reset release.
- Command ingress: all four inputs registered once (1 cycle). Registered byte written to cmd FIFO as {last,byte} whenever registered vld=1. Parity error = vld & ^{parity,byte}; o_parity_errors +1 per errored byte, saturating at 32'hFFFF_FFFF.
- Write when cmd FIFO full: byte discarded, o_cmd_overflows +1 (saturating); frame marked bad.
- o_udp_cmd_byte_rd <= (fill < CMD_FIFO_DEPTH-CMD_AFULL_MARGIN); fill counts uncommitted + committed entries.
- Commit: write of byte with last=1 commits frame (commit pointer <= write pointer+1), frame counter +1. Pop of byte with last=1 decrements counter; simultaneous commit and last-pop: counter unchanged. Counter width clog2(CMD_FIFO_DEPTH)+1, never wraps.
- Command egress (FWFT): o_cmd_byte_vld = committed data present; o_cmd_frame_avail = counter!=0. Uncommitted bytes never visible. Pop on vld & i_cmd_byte_rd; i_cmd_byte_rd with vld=0 ignored.
- Reply ingress: write on i_rpl_byte_vld & o_rpl_byte_rdy; o_rpl_byte_rdy = ~full (from registered pointers); write while not ready ignored.
- Reply egress: rd_q <= i_eth_frame_byte_rd. Each cycle, if rd_q & reply FIFO non-empty: pop, load output regs, o_eth_frame_byte_vld<=1; else vld<=0 (data regs hold). vld is low no later than 2 clocks after i_eth_frame_byte_rd falls; never asserted while rd_q=0. Bytes stream as soon as present (no frame gating). Parity = ^byte computed before output register.
- Simultaneous reply write and pop on same cycle (including empty->write) handled without loss; empty FIFO yields no pop that cycle.

Optional Feature:
Macro CS_UDP_CMD_DROP_BAD_FRAME_EN. Defined: frame containing any parity error or overflow is discarded at its last byte — write pointer rolls back to commit pointer, frame counter unchanged, o_frames_dropped +1 (saturating); local logic never sees it. Not defined: bad frames committed and forwarded normally, only counted in o_parity_errors/o_cmd_overflows; o_frames_dropped tied 0.

Test Plan:
Reset then 10-byte command frame 0x00..0x09, good parity -> o_cmd_frame_avail=1 after last write; bytes out in order, o_cmd_last_byte only on 0x09; counter returns 0.
Byte 0x03 sent with parity=1 in 5-byte frame -> o_parity_errors=1; feature on: no output, o_frames_dropped=1; feature off: frame delivered.
Continuous cmd stream, i_cmd_byte_rd=0 -> rd drops when fill reaches 496; ETH keeps vld 4 more cycles -> no overflow, o_cmd_overflows=0.
Reply frame 64 bytes, i_eth_frame_byte_rd toggled low for 5 cycles mid-frame -> vld low within 2 cycles, no byte lost/duplicated, parity correct on each, last on byte 64.
Last cmd byte written same cycle previous frame's last byte popped -> frame counter unchanged (1), next frame delivered.
Assert i_sys_rst_n low mid-frame both directions -> all outputs 0 immediately, FIFOs empty, counters 0; new frame after release delivered intact.

Source files
------------

// File: rtl/cs_udp_cmd_link_endpoint.sv
// CS-side endpoint of the ETH<->CS byte link: parity-checked, frame-committed command FIFO
// and parity-tagged reply stream. Option macro: CS_UDP_CMD_DROP_BAD_FRAME_EN (discard bad frames).
module cs_udp_cmd_link_endpoint #(
  parameter int CMD_FIFO_DEPTH   = 512,
  parameter int CMD_AFULL_MARGIN = 16,
  parameter int RPL_FIFO_DEPTH   = 2048
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst_n,
  input  logic        i_udp_cmd_byte_vld,
  input  logic        i_udp_cmd_last_byte,
  input  logic        i_udp_cmd_byte_parity,
  input  logic [7:0]  i_udp_cmd_byte,
  output logic        o_udp_cmd_byte_rd,
  output logic        o_cmd_frame_avail,
  output logic        o_cmd_byte_vld,
  output logic        o_cmd_last_byte,
  output logic [7:0]  o_cmd_byte,
  input  logic        i_cmd_byte_rd,
  input  logic        i_rpl_byte_vld,
  input  logic        i_rpl_last_byte,
  input  logic [7:0]  i_rpl_byte,
  output logic        o_rpl_byte_rdy,
  input  logic        i_eth_frame_byte_rd,
  output logic        o_eth_frame_byte_vld,
  output logic        o_eth_frame_last_byte,
  output logic        o_eth_frame_byte_parity,
  output logic [7:0]  o_eth_frame_byte,
  output logic [31:0] o_parity_errors,
  output logic [15:0] o_cmd_overflows,
  output logic [15:0] o_frames_dropped
);
  localparam int CAW = $clog2(CMD_FIFO_DEPTH);
  localparam int CPW = CAW + 1;
  localparam int RAW = $clog2(RPL_FIFO_DEPTH);
  localparam int RPW = RAW + 1;

  typedef struct packed { logic last; logic [7:0] data; } ent_t;

  logic       in_vld_q, in_last_q, in_par_q;
  logic [7:0] in_byte_q;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      in_vld_q  <= 1'b0;
      in_last_q <= 1'b0;
      in_par_q  <= 1'b0;
      in_byte_q <= '0;
    end else begin
      in_vld_q  <= i_udp_cmd_byte_vld;
      in_last_q <= i_udp_cmd_last_byte;
      in_par_q  <= i_udp_cmd_byte_parity;
      in_byte_q <= i_udp_cmd_byte;
    end
  end

  // Command FIFO: wr_ptr runs ahead of cmt_ptr; only [rd_ptr, cmt_ptr) is visible downstream.
  ent_t           cmd_mem [CMD_FIFO_DEPTH];
  ent_t           cmd_head;
  logic [CPW-1:0] wr_ptr, cmt_ptr, rd_ptr, frm_cnt, cmd_fill;
  logic           cmd_full, cmd_vld, par_err, ovf, eof, drop, wr_en, commit, pop;

  assign cmd_fill = wr_ptr - rd_ptr;
  assign cmd_full = (cmd_fill == CPW'(CMD_FIFO_DEPTH));
  assign cmd_vld  = (cmt_ptr != rd_ptr);
  assign cmd_head = cmd_mem[rd_ptr[CAW-1:0]];
  assign par_err  = in_vld_q & (^{in_par_q, in_byte_q});
  assign ovf      = in_vld_q & cmd_full;
  assign eof      = in_vld_q & in_last_q;
  assign wr_en    = in_vld_q & ~cmd_full & ~drop;
  assign commit   = eof & ~drop;
  assign pop      = cmd_vld & i_cmd_byte_rd;

  assign o_cmd_frame_avail = (frm_cnt != '0);
  assign o_cmd_byte_vld    = cmd_vld;
  assign o_cmd_last_byte   = cmd_vld & cmd_head.last;
  assign o_cmd_byte        = cmd_vld ? cmd_head.data : 8'h00;

`ifdef CS_UDP_CMD_DROP_BAD_FRAME_EN
  logic frame_bad_q;
  assign drop = eof & (frame_bad_q | par_err | ovf);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      frame_bad_q      <= 1'b0;
      o_frames_dropped <= '0;
    end else begin
      if (in_vld_q) frame_bad_q <= ~in_last_q & (frame_bad_q | par_err | ovf);
      if (drop && o_frames_dropped != '1) o_frames_dropped <= o_frames_dropped + 16'd1;
    end
  end
`else
  assign drop             = 1'b0;
  assign o_frames_dropped = '0;
`endif

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      wr_ptr            <= '0;
      cmt_ptr           <= '0;
      rd_ptr            <= '0;
      frm_cnt           <= '0;
      o_udp_cmd_byte_rd <= 1'b0;
      o_parity_errors   <= '0;
      o_cmd_overflows   <= '0;
    end else begin
      o_udp_cmd_byte_rd <= (cmd_fill < CPW'(CMD_FIFO_DEPTH - CMD_AFULL_MARGIN));
      if (drop)       wr_ptr <= cmt_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + CPW'(1);
      // A last byte lost to overflow still releases the bytes already stored.
      if (commit)     cmt_ptr <= wr_en ? wr_ptr + CPW'(1) : wr_ptr;
      if (pop)        rd_ptr <= rd_ptr + CPW'(1);
      case ({commit & wr_en, pop & cmd_head.last})
        2'b10:   frm_cnt <= frm_cnt + CPW'(1);
        2'b01:   frm_cnt <= frm_cnt - CPW'(1);
        default: ;
      endcase
      if (par_err && o_parity_errors != '1) o_parity_errors <= o_parity_errors + 32'd1;
      if (ovf && o_cmd_overflows != '1)     o_cmd_overflows <= o_cmd_overflows + 16'd1;
    end
  end

  always_ff @(posedge i_sys_clk)
    if (wr_en) cmd_mem[wr_ptr[CAW-1:0]] <= '{last: in_last_q, data: in_byte_q};

  ent_t           rpl_mem [RPL_FIFO_DEPTH];
  ent_t           rpl_head;
  logic [RPW-1:0] rwr_ptr, rrd_ptr;
  logic           rpl_full, rpl_empty, rpl_wr, rpl_pop, rd_q, run_q;

  assign rpl_full       = ((rwr_ptr - rrd_ptr) == RPW'(RPL_FIFO_DEPTH));
  assign rpl_empty      = (rwr_ptr == rrd_ptr);
  assign o_rpl_byte_rdy = run_q & ~rpl_full;
  assign rpl_wr         = i_rpl_byte_vld & o_rpl_byte_rdy;
  assign rpl_pop        = rd_q & ~rpl_empty;
  assign rpl_head       = rpl_mem[rrd_ptr[RAW-1:0]];

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      run_q                   <= 1'b0;
      rd_q                    <= 1'b0;
      rwr_ptr                 <= '0;
      rrd_ptr                 <= '0;
      o_eth_frame_byte_vld    <= 1'b0;
      o_eth_frame_last_byte   <= 1'b0;
      o_eth_frame_byte_parity <= 1'b0;
      o_eth_frame_byte        <= '0;
    end else begin
      run_q <= 1'b1;
      rd_q  <= i_eth_frame_byte_rd;
      if (rpl_wr) rwr_ptr <= rwr_ptr + RPW'(1);
      // Data regs hold when idle; only vld drops.
      o_eth_frame_byte_vld <= rpl_pop;
      if (rpl_pop) begin
        rrd_ptr                 <= rrd_ptr + RPW'(1);
        o_eth_frame_byte        <= rpl_head.data;
        o_eth_frame_last_byte   <= rpl_head.last;
        o_eth_frame_byte_parity <= ^rpl_head.data;
      end
    end
  end

  always_ff @(posedge i_sys_clk)
    if (rpl_wr) rpl_mem[rwr_ptr[RAW-1:0]] <= '{last: i_rpl_last_byte, data: i_rpl_byte};

endmodule

// File: tb/tb_cs_udp_cmd_link_endpoint.sv
// Directed bench for cs_udp_cmd_link_endpoint: command framing/parity/flow control,
// reply streaming with back-pressure, and async reset mid-traffic.
module tb_cs_udp_cmd_link_endpoint;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        udp_vld, udp_last, udp_par, udp_rd;
  logic [7:0]  udp_byte, cmd_byte, rpl_byte, eth_byte;
  logic        frame_avail, cmd_vld, cmd_last, cmd_rd;
  logic        rpl_vld, rpl_last, rpl_rdy;
  logic        eth_rd, eth_vld, eth_last, eth_par;
  logic [31:0] par_errs;
  logic [15:0] ovfs, dropped;
  logic [87:0] all_outs;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  cs_udp_cmd_link_endpoint dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n),
    .i_udp_cmd_byte_vld(udp_vld), .i_udp_cmd_last_byte(udp_last),
    .i_udp_cmd_byte_parity(udp_par), .i_udp_cmd_byte(udp_byte),
    .o_udp_cmd_byte_rd(udp_rd), .o_cmd_frame_avail(frame_avail),
    .o_cmd_byte_vld(cmd_vld), .o_cmd_last_byte(cmd_last), .o_cmd_byte(cmd_byte),
    .i_cmd_byte_rd(cmd_rd), .i_rpl_byte_vld(rpl_vld), .i_rpl_last_byte(rpl_last),
    .i_rpl_byte(rpl_byte), .o_rpl_byte_rdy(rpl_rdy), .i_eth_frame_byte_rd(eth_rd),
    .o_eth_frame_byte_vld(eth_vld), .o_eth_frame_last_byte(eth_last),
    .o_eth_frame_byte_parity(eth_par), .o_eth_frame_byte(eth_byte),
    .o_parity_errors(par_errs), .o_cmd_overflows(ovfs), .o_frames_dropped(dropped)
  );

  assign all_outs = {udp_rd, frame_avail, cmd_vld, cmd_last, cmd_byte, rpl_rdy, eth_vld,
                     eth_last, eth_par, eth_byte, par_errs, ovfs, dropped};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    udp_vld = 1'b0; udp_last = 1'b0; udp_par = 1'b0; udp_byte = '0; cmd_rd = 1'b0;
    rpl_vld = 1'b0; rpl_last = 1'b0; rpl_byte = '0; eth_rd = 1'b0;
  endtask

  task automatic drive_cmd(input logic [7:0] b, input logic last, input logic bad);
    udp_vld = 1'b1; udp_last = last; udp_byte = b; udp_par = (^b) ^ bad;
    tick();
    udp_vld = 1'b0; udp_last = 1'b0;
  endtask

  task automatic pop(output logic v, output logic [7:0] b, output logic l);
    v = cmd_vld; b = cmd_byte; l = cmd_last;
    cmd_rd = 1'b1; tick(); cmd_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; repeat (3) tick();
    n_cmp++; if (all_outs !== '0) begin n_bad++; $display("FAIL reset_outs got=%h exp=0", all_outs); end
    rst_n = 1'b1; tick();
    n_cmp++; if ({udp_rd, rpl_rdy, frame_avail, cmd_vld} !== 4'b1100) begin
      n_bad++; $display("FAIL reset_release got=%b exp=1100", {udp_rd, rpl_rdy, frame_avail, cmd_vld}); end
  endtask

  task automatic test_cmd_frame();
    logic v, l; logic [7:0] b;
    for (int i = 0; i < 10; i++) drive_cmd(8'(i), i == 9, 1'b0);
    n_cmp++; if ({frame_avail, cmd_vld} !== 2'b00) begin
      n_bad++; $display("FAIL uncommitted_hidden got=%b exp=00", {frame_avail, cmd_vld}); end
    tick();
    n_cmp++; if ({frame_avail, cmd_vld} !== 2'b11) begin
      n_bad++; $display("FAIL frame_avail got=%b exp=11", {frame_avail, cmd_vld}); end
    for (int i = 0; i < 10; i++) begin
      pop(v, b, l);
      n_cmp++; if ({v, b, l} !== {1'b1, 8'(i), i == 9}) begin
        n_bad++; $display("FAIL cmd_byte%0d got=%b/%h/%b exp=1/%h/%b", i, v, b, l, 8'(i), i == 9); end
    end
    n_cmp++; if ({frame_avail, cmd_vld} !== 2'b00) begin
      n_bad++; $display("FAIL cmd_drained got=%b exp=00", {frame_avail, cmd_vld}); end
  endtask

  task automatic test_parity();
    logic v, l; logic [7:0] b;
    for (int i = 1; i <= 5; i++) drive_cmd(8'(i), i == 5, i == 3);
    tick(); tick();
    n_cmp++; if (par_errs !== 32'd1) begin n_bad++; $display("FAIL parity_count got=%0d exp=1", par_errs); end
`ifdef CS_UDP_CMD_DROP_BAD_FRAME_EN
    n_cmp++; if ({frame_avail, cmd_vld, dropped} !== {2'b00, 16'd1}) begin
      n_bad++; $display("FAIL bad_frame_drop got=%b%b/%0d exp=00/1", frame_avail, cmd_vld, dropped); end
`else
    for (int i = 1; i <= 5; i++) begin
      pop(v, b, l);
      n_cmp++; if ({v, b, l} !== {1'b1, 8'(i), i == 5}) begin
        n_bad++; $display("FAIL bad_frame_byte%0d got=%b/%h/%b exp=1/%h/%b", i, v, b, l, 8'(i), i == 5); end
    end
    n_cmp++; if ({frame_avail, cmd_vld, dropped} !== {2'b00, 16'd0}) begin
      n_bad++; $display("FAIL bad_frame_fwd got=%b%b/%0d exp=00/0", frame_avail, cmd_vld, dropped); end
`endif
  endtask

  task automatic test_afull();
    int sent = 0, hi = 0, post = 0, errs = 0;
    logic low_seen = 1'b0; logic v, l; logic [7:0] b;
    while (post < 4 && sent < 600) begin
      if (!udp_rd) low_seen = 1'b1;
      if (low_seen) post++; else hi++;
      udp_vld = 1'b1; udp_byte = 8'(sent); udp_par = ^udp_byte; udp_last = (post == 4);
      sent++; tick();
    end
    udp_vld = 1'b0; udp_last = 1'b0;
    repeat (3) tick();
    n_cmp++; if (hi !== 498) begin n_bad++; $display("FAIL afull_rd_drop got=%0d exp=498", hi); end
    n_cmp++; if (sent !== 502) begin n_bad++; $display("FAIL afull_sent got=%0d exp=502", sent); end
    n_cmp++; if ({ovfs, frame_avail, udp_rd} !== {16'd0, 2'b10}) begin
      n_bad++; $display("FAIL afull_state got=%0d/%b%b exp=0/10", ovfs, frame_avail, udp_rd); end
    for (int k = 0; k < 502; k++) begin
      pop(v, b, l);
      if ({v, b, l} !== {1'b1, 8'(k), k == 501}) errs++;
    end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL afull_drain got=%0d errs exp=0", errs); end
    tick();
    n_cmp++; if ({udp_rd, frame_avail, cmd_vld} !== 3'b100) begin
      n_bad++; $display("FAIL afull_empty got=%b exp=100", {udp_rd, frame_avail, cmd_vld}); end
  endtask

  task automatic test_back_to_back();
    logic v, l; logic [7:0] b;
    drive_cmd(8'h10, 1'b0, 1'b0); drive_cmd(8'h11, 1'b1, 1'b0); tick(); tick();
    pop(v, b, l);
    n_cmp++; if ({v, b, l} !== {1'b1, 8'h10, 1'b0}) begin
      n_bad++; $display("FAIL b2b_a0 got=%b/%h/%b exp=1/10/0", v, b, l); end
    drive_cmd(8'h12, 1'b0, 1'b0); drive_cmd(8'h13, 1'b1, 1'b0);
    n_cmp++; if ({cmd_vld, cmd_byte, cmd_last} !== {1'b1, 8'h11, 1'b1}) begin
      n_bad++; $display("FAIL b2b_a1 got=%b/%h/%b exp=1/11/1", cmd_vld, cmd_byte, cmd_last); end
    cmd_rd = 1'b1; tick(); cmd_rd = 1'b0;
    n_cmp++; if ({frame_avail, cmd_vld, cmd_byte, cmd_last} !== {2'b11, 8'h12, 1'b0}) begin
      n_bad++; $display("FAIL b2b_count got=%b%b/%h/%b exp=11/12/0", frame_avail, cmd_vld, cmd_byte, cmd_last); end
    pop(v, b, l);
    n_cmp++; if ({v, b, l} !== {1'b1, 8'h12, 1'b0}) begin
      n_bad++; $display("FAIL b2b_b0 got=%b/%h/%b exp=1/12/0", v, b, l); end
    pop(v, b, l);
    n_cmp++; if ({v, b, l} !== {1'b1, 8'h13, 1'b1}) begin
      n_bad++; $display("FAIL b2b_b1 got=%b/%h/%b exp=1/13/1", v, b, l); end
    n_cmp++; if ({frame_avail, cmd_vld} !== 2'b00) begin
      n_bad++; $display("FAIL b2b_end got=%b exp=00", {frame_avail, cmd_vld}); end
  endtask

  task automatic test_reply();
    int wr_i = 0, rx = 0, errs = 0, viol = 0;
    logic rd_d1 = 1'b0, rd_d2 = 1'b0; logic [7:0] e;
    for (int n = 0; n < 400 && rx < 64; n++) begin
      if (eth_vld) begin
        e = 8'(rx) ^ 8'h5A;
        if (eth_byte !== e || eth_par !== ^e || eth_last !== (rx == 63)) errs++;
        if (!rd_d2) viol++;
        rx++;
      end
      if (wr_i < 64) begin
        rpl_vld = 1'b1; rpl_byte = 8'(wr_i) ^ 8'h5A; rpl_last = (wr_i == 63);
        if (rpl_rdy) wr_i++;
      end else rpl_vld = 1'b0;
      eth_rd = !(n >= 20 && n < 25);
      rd_d2 = rd_d1; rd_d1 = eth_rd;
      tick();
    end
    rpl_vld = 1'b0; rpl_last = 1'b0; eth_rd = 1'b0;
    n_cmp++; if (rx !== 64) begin n_bad++; $display("FAIL reply_count got=%0d exp=64", rx); end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL reply_data got=%0d errs exp=0", errs); end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL reply_backpressure got=%0d viol exp=0", viol); end
    tick(); tick();
    n_cmp++; if ({eth_vld, rpl_rdy} !== 2'b01) begin
      n_bad++; $display("FAIL reply_idle got=%b exp=01", {eth_vld, rpl_rdy}); end
  endtask

  task automatic test_reset_mid();
    int rx = 0, errs = 0; logic v, l; logic [7:0] b, e;
    drive_cmd(8'h20, 1'b0, 1'b0); drive_cmd(8'h21, 1'b1, 1'b0);
    drive_cmd(8'h22, 1'b0, 1'b1); drive_cmd(8'h23, 1'b0, 1'b0);
    eth_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin rpl_vld = 1'b1; rpl_byte = 8'(i); rpl_last = 1'b0; tick(); end
    rpl_vld = 1'b0;
    n_cmp++; if ({frame_avail, eth_vld, par_errs} !== {2'b11, 32'd2}) begin
      n_bad++; $display("FAIL pre_reset got=%b%b/%0d exp=11/2", frame_avail, eth_vld, par_errs); end
    #2 rst_n = 1'b0; clear_inputs();
    #1;
    n_cmp++; if (all_outs !== '0) begin n_bad++; $display("FAIL midreset_outs got=%h exp=0", all_outs); end
    tick(); tick(); rst_n = 1'b1; tick();
    n_cmp++; if ({udp_rd, frame_avail, cmd_vld, eth_vld} !== 4'b1000) begin
      n_bad++; $display("FAIL post_reset got=%b exp=1000", {udp_rd, frame_avail, cmd_vld, eth_vld}); end
    for (int i = 0; i < 3; i++) drive_cmd(8'(8'h30 + i), i == 2, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      pop(v, b, l);
      n_cmp++; if ({v, b, l} !== {1'b1, 8'(8'h30 + i), i == 2}) begin
        n_bad++; $display("FAIL post_reset_cmd%0d got=%b/%h/%b exp=1/%h/%b", i, v, b, l, 8'(8'h30 + i), i == 2); end
    end
    n_cmp++; if ({cmd_vld, frame_avail, par_errs} !== {2'b00, 32'd0}) begin
      n_bad++; $display("FAIL post_reset_empty got=%b%b/%0d exp=00/0", cmd_vld, frame_avail, par_errs); end
    eth_rd = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (eth_vld) begin
        e = 8'h41 + 8'(rx);
        if (eth_byte !== e || eth_par !== ^e || eth_last !== (rx == 1)) errs++;
        rx++;
      end
      rpl_vld = (n < 2); rpl_byte = 8'h41 + 8'(n); rpl_last = (n == 1);
      tick();
    end
    rpl_vld = 1'b0; eth_rd = 1'b0;
    n_cmp++; if ({rx, errs} !== {32'd2, 32'd0}) begin
      n_bad++; $display("FAIL post_reset_reply got=%0d bytes/%0d errs exp=2/0", rx, errs); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_cmd_frame();
    test_parity();
    test_afull();
    test_back_to_back();
    test_reply();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
